// File: rtl/multiplier_datapath_pkg.sv
// multiplier_pkg: shared width, strobe-to-operation encoding and priority decode
package multiplier_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [2:0] {OP_HOLD, OP_CLRLD, OP_SUB, OP_ADD, OP_SHIFT} dp_op_t;

    // Several strobes high on one edge resolve as Clr_Ld > Sub > Add > Shift_En
    function automatic dp_op_t decode_op(input logic clr_ld, input logic sub, input logic add, input logic shift_en);
        return clr_ld ? OP_CLRLD : sub ? OP_SUB : add ? OP_ADD : shift_en ? OP_SHIFT : OP_HOLD;
    endfunction

endpackage

// File: rtl/multiplier_datapath_if.sv
// multiplier_datapath_if: control strobes from the FSM and register views back to it
interface multiplier_datapath_if #(parameter int WIDTH = multiplier_pkg::WIDTH);

    logic [WIDTH-1:0] S;
    logic             Clr_Ld;
    logic             Shift_En;
    logic             Add;
    logic             Sub;
    logic             M;
    logic             X;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;

    modport master (output S, Clr_Ld, Shift_En, Add, Sub, input M, X, Aval, Bval);
    modport slave  (input S, Clr_Ld, Shift_En, Add, Sub, output M, X, Aval, Bval);

endinterface

// File: rtl/multiplier_datapath_add_sub_9.sv
// add_sub_9: ripple-carry adder/subtractor; sub inverts b and injects the +1 as carry-in
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_sub_9 #(parameter int N = 9) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s
);
    logic [N-1:0] bx;
    logic [N-1:0] c;

    assign bx   = b ^ {N{sub}};
    assign c[0] = sub;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            if (i < N - 1) begin : g_fa
                full_adder u_fa (.a(a[i]), .b(bx[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
            end else begin : g_msb
                // Result is modulo 2^N, so the top stage needs no carry out
                assign s[i] = a[i] ^ bx[i] ^ c[i];
            end
        end
    endgenerate
endmodule

// File: rtl/multiplier_datapath.sv
// multiplier_datapath: X/A/B registers and sign-extended add/sub for the shift-add multiplier
module multiplier_datapath
    import multiplier_pkg::*;
#(
    parameter int WIDTH = multiplier_pkg::WIDTH
) (
    input logic                  Clk,
    input logic                  Reset,
    multiplier_datapath_if.slave bus
);

    dp_op_t           op;
    logic [WIDTH:0]   sum;
    logic             x_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    assign op = decode_op(bus.Clr_Ld, bus.Sub, bus.Add, bus.Shift_En);

    add_sub_9 #(.N(WIDTH + 1)) u_add_sub (
        .a   ({a_q[WIDTH-1], a_q}),
        .b   ({bus.S[WIDTH-1], bus.S}),
        .sub (op == OP_SUB),
        .s   (sum)
    );

    // Register update: reset beats every strobe, otherwise the decoded operation applies
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            case (op)
                OP_CLRLD: begin
                    x_q <= 1'b0;
                    a_q <= '0;
                    b_q <= bus.S;
                end
                OP_ADD, OP_SUB: {x_q, a_q} <= sum;
                OP_SHIFT:       {a_q, b_q} <= {x_q, a_q, b_q[WIDTH-1:1]};
                default: ;
            endcase
        end
    end

    assign bus.M    = b_q[0];
    assign bus.X    = x_q;
    assign bus.Aval = a_q;
    assign bus.Bval = b_q;

endmodule
